// File: rtl/fir_mac_pkg.sv
// Shared types and width/limit helpers for the interleaved FIR multiply-accumulate pipeline.
package fir_mac_pkg;

    localparam int CH_FIELD_W = 4;

    typedef struct packed {
        logic                  valid;
        logic [CH_FIELD_W-1:0] ch;
        logic                  first;
        logic                  last;
    } sideband_t;

    // The coefficient gains one extension bit, so the exact product needs one bit beyond the sum.
    function automatic int prod_w(input int din0_w, input int din1_w);
        return din0_w + din1_w + 1;
    endfunction

    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int w);
        return ~sat_max(w);
    endfunction

endpackage

// File: rtl/fir_mac_mul.sv
// Full-precision signed multiplier with a configurable number of register stages; the sideband rides along.
module fir_mac_mul
    import fir_mac_pkg::*;
#(
    parameter int  DIN0_W      = 16,
    parameter int  DIN1_W      = 7,
    parameter int  COEF_SIGNED = 0,
    parameter int  MUL_STAGES  = 1,
    localparam int PW          = prod_w(DIN0_W, DIN1_W)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic [DIN0_W-1:0]    data_i,
    input  logic [DIN1_W-1:0]    coef_i,
    input  sideband_t            sb_i,
    output logic signed [PW-1:0] prod_o,
    output sideband_t            sb_o
);

    localparam int NREG = (MUL_STAGES > 0) ? MUL_STAGES : 1;

    logic signed [PW-1:0] data_x;
    logic signed [PW-1:0] coef_x;
    logic signed [PW-1:0] prod_d;

    always_comb begin
        data_x = PW'($signed(data_i));
        if (COEF_SIGNED != 0) begin
            coef_x = PW'($signed(coef_i));
        end else begin
            coef_x = PW'(coef_i);
        end
        prod_d = data_x * coef_x;
    end

    logic signed [PW-1:0] prod_q [NREG];
    sideband_t            sb_q   [NREG];

    generate
        if (MUL_STAGES == 0) begin : g_comb
            assign prod_o = prod_d;
            assign sb_o   = sb_i;
        end else begin : g_pipe
            for (genvar gi = 0; gi < MUL_STAGES; gi++) begin : g_stage
                logic signed [PW-1:0] prod_in;
                sideband_t            sb_in;
                if (gi == 0) begin : g_head
                    assign prod_in = prod_d;
                    assign sb_in   = sb_i;
                end else begin : g_tail
                    assign prod_in = prod_q[gi-1];
                    assign sb_in   = sb_q[gi-1];
                end
                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) begin
                        prod_q[gi] <= '0;
                        sb_q[gi]   <= '0;
                    end else if (en_i) begin
                        prod_q[gi] <= prod_in;
                        sb_q[gi]   <= sb_in;
                    end
                end
            end
            assign prod_o = prod_q[MUL_STAGES-1];
            assign sb_o   = sb_q[MUL_STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/fir_mac_pipe.sv
// Interleaved-channel FIR multiply-accumulate: product pipeline, per-channel accumulators, one output register.
module fir_mac_pipe
    import fir_mac_pkg::*;
#(
    parameter int  DIN0_W      = 16,
    parameter int  DIN1_W      = 7,
    parameter int  COEF_SIGNED = 0,
    parameter int  MUL_STAGES  = 1,
    parameter int  ACC_W       = 32,
    parameter int  NUM_CH      = 2,
    parameter int  SAT         = 0,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int PW          = prod_w(DIN0_W, DIN1_W)
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DIN0_W-1:0]       in_data,
    input  logic [DIN1_W-1:0]       in_coef,
    input  logic [CH_W-1:0]         in_ch,
    input  logic                    in_first,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_data,
    output logic [CH_W-1:0]         out_ch,
    output logic                    out_ovf
);

    localparam logic [63:0]             MAX_L   = sat_max(ACC_W);
    localparam logic [63:0]             MIN_L   = sat_min(ACC_W);
    localparam logic signed [ACC_W-1:0] ACC_MAX = MAX_L[ACC_W-1:0];
    localparam logic signed [ACC_W-1:0] ACC_MIN = MIN_L[ACC_W-1:0];

    logic                    en;
    sideband_t               sb_in;
    sideband_t               sb_m;
    logic signed [PW-1:0]    prod_m;
    logic [CH_W-1:0]         ch_idx;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_cur;
    logic signed [ACC_W-1:0] sum;
    logic                    add_ovf;
    logic signed [ACC_W-1:0] acc_d;
    logic                    ovf_d;

    logic signed [ACC_W-1:0] acc_q [NUM_CH];
    logic                    ovf_q [NUM_CH];
    logic                    out_valid_q;
    logic signed [ACC_W-1:0] out_data_q;
    logic [CH_W-1:0]         out_ch_q;
    logic                    out_ovf_q;

    // One enable stalls every stage together, so a full output register back-pressures the input.
    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    always_comb begin
        sb_in       = '0;
        sb_in.valid = in_valid && ({1'b0, in_ch} < (CH_W+1)'(NUM_CH));
        sb_in.ch    = CH_FIELD_W'(in_ch);
        sb_in.first = in_first;
        sb_in.last  = in_last;
    end

    fir_mac_mul #(
        .DIN0_W      (DIN0_W),
        .DIN1_W      (DIN1_W),
        .COEF_SIGNED (COEF_SIGNED),
        .MUL_STAGES  (MUL_STAGES)
    ) u_mul (
        .clk_i  (ap_clk),
        .rst_ni (ap_rst_n),
        .en_i   (en),
        .data_i (in_data),
        .coef_i (in_coef),
        .sb_i   (sb_in),
        .prod_o (prod_m),
        .sb_o   (sb_m)
    );

    assign ch_idx = sb_m.ch[CH_W-1:0];

    always_comb begin
        prod_ext = ACC_W'(prod_m);
        acc_cur  = acc_q[ch_idx];
        sum      = acc_cur + prod_ext;
        add_ovf  = (acc_cur[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_cur[ACC_W-1]);
        if (sb_m.first) begin
            acc_d = prod_ext;
            ovf_d = 1'b0;
        end else begin
            acc_d = sum;
            if ((SAT != 0) && add_ovf) begin
                acc_d = acc_cur[ACC_W-1] ? ACC_MIN : ACC_MAX;
            end
            ovf_d = ovf_q[ch_idx] | add_ovf;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_acc
            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    acc_q[gi] <= '0;
                    ovf_q[gi] <= 1'b0;
                end else if (en && sb_m.valid && (ch_idx == CH_W'(gi))) begin
                    acc_q[gi] <= acc_d;
                    ovf_q[gi] <= ovf_d;
                end
            end
        end
    endgenerate

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_ovf_q   <= 1'b0;
        end else if (en) begin
            out_valid_q <= sb_m.valid && sb_m.last;
            if (sb_m.valid && sb_m.last) begin
                out_data_q <= acc_d;
                out_ch_q   <= ch_idx;
                out_ovf_q  <= ovf_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: doc/fir_mac_pipe.md
FIR_MAC_PIPE -- requirements
Module: fir_mac_pipe

Interface
REQ-001 SHALL have parameter DIN0_W, default 16, meaning sample width (always signed).
REQ-002 SHALL have parameter DIN1_W, default 7, meaning coefficient width.
REQ-003 SHALL have parameter COEF_SIGNED, default 0, meaning 1 treats the coefficient as signed and 0 zero-extends it by one bit.
REQ-004 SHALL have parameter MUL_STAGES, default 1, range 0..4, meaning product register stages.
REQ-005 SHALL have parameter ACC_W, default 32, range at least DIN0_W+DIN1_W+1, meaning accumulator and result width.
REQ-006 SHALL have parameter NUM_CH, default 2, range 1..16, meaning interleaved channel accumulators.
REQ-007 SHALL have parameter SAT, default 0, meaning 1 saturates on overflow and 0 wraps.
REQ-008 SHALL have port ap_clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-009 SHALL have port ap_rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-010 SHALL have ports in_valid (in, 1), in_ready (out, 1), in_data (in, DIN0_W, signed sample), in_coef (in, DIN1_W), in_ch (in, clog2(NUM_CH) min 1), in_first (in, 1, starts accumulation) and in_last (in, 1, ends accumulation).
REQ-011 SHALL have ports out_valid (out, 1), out_ready (in, 1), out_data (out, ACC_W, signed result), out_ch (out, channel of result) and out_ovf (out, 1, overflow occurred in this result).

Function
REQ-012 Product SHALL be the full-precision signed product of in_data and the extended coefficient, DIN0_W+DIN1_W+1 bits, sign-extended to ACC_W.
REQ-013 Beat SHALL be accepted when in_valid and in_ready are both 1.
REQ-014 Global enable en = !out_valid || out_ready; in_ready SHALL equal en; all pipeline stages SHALL advance only when en=1.
REQ-015 Valid, channel, first and last flags SHALL travel alongside the product through MUL_STAGES registers; bubbles SHALL NOT modify accumulators.
REQ-016 Accumulate stage: if first=1, acc[ch] becomes the product; otherwise acc[ch] becomes acc[ch] plus the product; ovf[ch] SHALL be cleared on first and OR-ed with the stage overflow otherwise.
REQ-017 Overflow SHALL be detected as a sign mismatch of the ACC_W addition; with SAT=1 the result SHALL clamp to max or min of ACC_W; with SAT=0 it SHALL wrap.
REQ-018 If last=1, the updated acc[ch], ch and ovf SHALL load into the output register with out_valid=1 on the same edge.
REQ-019 Latency SHALL be MUL_STAGES+1 cycles from accepting a last beat to out_valid=1, in the absence of stalls.
REQ-020 first=1 and last=1 on the same beat SHALL output the single product.
REQ-021 Output SHALL hold stable while out_valid=1 and out_ready=0; out_valid SHALL clear on out_ready=1 unless a new result loads on the same edge.
REQ-022 in_ch values of NUM_CH or more SHALL be dropped: no accumulator update and no output.
REQ-023 Throughput SHALL be one beat per cycle when out_ready=1 continuously.

Reset
REQ-024 When ap_rst_n=0, all pipeline valids, out_valid, out_data, out_ch, out_ovf, and all acc and ovf entries SHALL be 0 immediately; in_ready SHALL be 1.
REQ-025 Reset mid-accumulation SHALL discard all partial sums; a following beat with first=0 SHALL accumulate onto 0.

Structure
REQ-026 Shared package fir_mac_pkg SHALL hold the product-width and saturation-limit functions and the sideband struct (valid, ch, first, last).
REQ-027 Product pipeline SHALL be sub-module fir_mac_mul, parametrised by DIN0_W, DIN1_W, COEF_SIGNED and MUL_STAGES, with an enable input.
REQ-028 Accumulators SHALL be a register array of NUM_CH entries; no RAM inference is required.

Verification
REQ-029 Defaults with taps (100,3), (-50,127), (7,0) on ch0, first on tap 1 and last on tap 3 -> out_data=-6050, out_ch=0, ovf=0, two cycles after tap 3.
REQ-030 Interleave ch0 and ch1, each a 4-tap sequence of (1,1) -> two results, each of value 4, with the matching out_ch.
REQ-031 ACC_W=23, SAT=1, repeated (-32768,127) -> clamp to -4194304 with ovf=1; with SAT=0, the wrapped value and ovf=1.
REQ-032 Hold out_ready=0 for 5 cycles during a stream -> in_ready=0, output stable, no beat lost, correct sums afterward.
REQ-033 COEF_SIGNED=1 with in_coef=7'h7F and in_data=2, first and last set -> out_data=-2; with COEF_SIGNED=0 -> 254.
REQ-034 Assert ap_rst_n=0 mid-sequence -> outputs 0 asynchronously; a post-reset beat (5,5) with first=0 and last=1 -> 25.
